// File: rtl/rx_cross_port_arbiter.sv
// Frame-level round-robin merge of PORT_NUM RX streams onto one AXI-Stream output.
// Latency: 1-cycle grant decision in IDLE, then beats pass combinationally from the granted port.
// Backpressure: downstream ready is routed only to the granted port; all others are held off until the frame ends.
module rx_cross_port_arbiter #(
  parameter int PORT_NUM         = 4,
  parameter int CROSS_DATA_WIDTH = 32,
  parameter int ID_WIDTH         = 2
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [PORT_NUM-1:0]                       i_port_link,
  input  logic [PORT_NUM*(CROSS_DATA_WIDTH+1)-1:0]  i_port_axi_data,
  input  logic [PORT_NUM*(CROSS_DATA_WIDTH/8)-1:0]  i_port_axi_keep,
  input  logic [PORT_NUM-1:0]                       i_port_axi_valid,
  input  logic [PORT_NUM-1:0]                       i_port_axi_last,
  output logic [PORT_NUM-1:0]                       o_port_axi_ready,
  output logic [CROSS_DATA_WIDTH:0]                 o_arb_axi_data,
  output logic [CROSS_DATA_WIDTH/8-1:0]             o_arb_axi_keep,
  output logic                                      o_arb_axi_valid,
  output logic                                      o_arb_axi_last,
  input  logic                                      i_arb_axi_ready,
  output logic [ID_WIDTH-1:0]                       o_arb_port_id,
  output logic                                      o_arb_busy
);

  localparam int DW = CROSS_DATA_WIDTH + 1;
  localparam int KW = CROSS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] next_grant;
  logic [PORT_NUM-1:0] req;
  logic                last_accepted;

  logic [DW-1:0] port_data [PORT_NUM];
  logic [KW-1:0] port_keep [PORT_NUM];

  // Split the flat per-port buses into indexable slices.
  always_comb begin
    for (int n = 0; n < PORT_NUM; n++) begin
      port_data[n] = i_port_axi_data[n*DW +: DW];
      port_keep[n] = i_port_axi_keep[n*KW +: KW];
    end
  end

  // A port only competes while its link is up and it has a beat to offer.
  always_comb begin
    req = i_port_axi_valid & i_port_link;
  end

  // Round-robin pick: nearest requester after last_grant; smaller offsets are visited last so they win.
  always_comb begin
    next_grant = last_grant;
    for (int i = PORT_NUM; i >= 1; i--) begin
      for (int j = 0; j < PORT_NUM; j++) begin
        if (req[j] && (j == (int'(last_grant) + i) % PORT_NUM)) begin
          next_grant = ID_WIDTH'(j);
        end
      end
    end
  end

  // End-of-frame handshake on the granted port; takes priority over a coincident link drop.
  always_comb begin
    last_accepted = i_port_axi_valid[grant] & i_arb_axi_ready & i_port_axi_last[grant];
  end

  // Arbiter FSM: grant held for a whole frame, link loss mid-frame closes it with an error beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_WIDTH'(PORT_NUM - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= next_grant;
            state <= XFER;
          end
        end
        XFER: begin
          if (last_accepted) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (!i_port_link[grant]) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (i_arb_axi_ready) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output steering: mirror the granted port in XFER, synthesize a crcerr terminator in FLUSH.
  always_comb begin
    o_port_axi_ready = '0;
    o_arb_axi_data   = '0;
    o_arb_axi_keep   = '0;
    o_arb_axi_valid  = 1'b0;
    o_arb_axi_last   = 1'b0;
    o_arb_port_id    = '0;
    o_arb_busy       = 1'b0;
    if (!i_rst) begin
      case (state)
        XFER: begin
          o_arb_axi_data          = port_data[grant];
          o_arb_axi_keep          = port_keep[grant];
          o_arb_axi_valid         = i_port_axi_valid[grant];
          o_arb_axi_last          = i_port_axi_last[grant];
          o_port_axi_ready[grant] = i_arb_axi_ready;
          o_arb_port_id           = grant;
          o_arb_busy              = 1'b1;
        end
        FLUSH: begin
          o_arb_axi_data  = {1'b1, {CROSS_DATA_WIDTH{1'b0}}};
          o_arb_axi_keep  = KW'(1);
          o_arb_axi_valid = 1'b1;
          o_arb_axi_last  = 1'b1;
          o_arb_port_id   = grant;
          o_arb_busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rx_cross_port_arbiter.md
RX_CROSS_PORT_ARBITER -- requirements
Module: rx_cross_port_arbiter

Interface
REQ-001 SHALL have parameter PORT_NUM, default 4, meaning the number of aggregated RX port streams.
REQ-002 SHALL have parameter CROSS_DATA_WIDTH, default 32, meaning the per-port aggregated payload width; each data bus is CROSS_DATA_WIDTH+1 bits, with the MSB as the crcerr flag.
REQ-003 SHALL have parameter ID_WIDTH, default 2, meaning the port-index width (clog2(PORT_NUM)).
REQ-004 i_clk  input  1  the single clock (250 MHz); one clock; reset is synchronous and active-high.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_port_link  input  PORT_NUM  per-port link status.
REQ-007 i_port_axi_data  input  PORT_NUM*(CROSS_DATA_WIDTH+1)  per-port data; port n occupies slice n.
REQ-008 i_port_axi_keep  input  PORT_NUM*(CROSS_DATA_WIDTH/8)  per-port byte keep.
REQ-009 i_port_axi_valid  input  PORT_NUM  per-port valid.
REQ-010 i_port_axi_last  input  PORT_NUM  per-port end of frame.
REQ-011 o_port_axi_ready  output  PORT_NUM  per-port ready (backpressure).
REQ-012 o_arb_axi_data  output  CROSS_DATA_WIDTH+1  merged data.
REQ-013 o_arb_axi_keep  output  CROSS_DATA_WIDTH/8  merged keep.
REQ-014 o_arb_axi_valid  output  1  merged valid.
REQ-015 o_arb_axi_last  output  1  merged end of frame.
REQ-016 i_arb_axi_ready  input  1  downstream ready.
REQ-017 o_arb_port_id  output  ID_WIDTH  source port of the current beat.
REQ-018 o_arb_busy  output  1  high while a frame is granted.

Function
REQ-019 SHALL implement the FSM IDLE -> XFER -> IDLE, plus FLUSH entered only from XFER.
REQ-020 A port SHALL request when both i_port_axi_valid[n] and i_port_link[n] are high.
REQ-021 In IDLE with any request, the block SHALL register grant = first requester searched cyclically from last_grant+1; go to XFER next cycle; no beat is passed in the decision cycle (1-cycle grant latency).
REQ-022 In XFER, the output bus SHALL combinationally mirror the granted port's data, keep, valid and last.
REQ-023 In XFER, o_port_axi_ready[grant] SHALL equal i_arb_axi_ready; all other ready bits SHALL be 0.
REQ-024 o_arb_port_id SHALL equal grant during XFER and FLUSH.
REQ-025 Arbitration SHALL be frame-level: grant is held until a beat with valid&ready&last; on that beat, last_grant<=grant and the FSM returns to IDLE.
REQ-026 Back-to-back frames SHALL incur exactly 1 idle cycle between them.
REQ-027 Valid low mid-frame SHALL hold the grant (no timeout).
REQ-028 If i_port_link[grant] falls during XFER, the block SHALL enter FLUSH next cycle; ready[grant]=0 from that cycle.
REQ-029 In FLUSH, the block SHALL output one beat: valid=1, last=1, data=0 with MSB=1 (crcerr), keep=1 in the lowest bit only; hold it until i_arb_axi_ready; then last_grant<=grant and return to IDLE.
REQ-030 A link drop in the same cycle as the accepted last beat SHALL give a normal completion, not FLUSH.
REQ-031 Port requests that arrive during XFER/FLUSH SHALL wait; no grant change occurs mid-frame.
REQ-032 In IDLE, o_arb_axi_valid SHALL be 0, o_arb_axi_last 0, o_port_axi_ready all 0, and o_arb_busy 0.
REQ-033 o_arb_busy SHALL be 1 in XFER and FLUSH.

Reset
REQ-034 On i_rst at a clock edge, the FSM SHALL go to IDLE, with grant=0 and last_grant=PORT_NUM-1 (port 0 has first priority).
REQ-035 During and after reset, o_arb_axi_valid=0, o_arb_axi_last=0, o_port_axi_ready=0, o_arb_port_id=0, o_arb_busy=0, and the data/keep outputs are 0.
REQ-036 Reset mid-frame SHALL abandon the frame with no FLUSH beat; the partially sent frame is the downstream's responsibility.

Verification
REQ-037 After reset, ports 0-3 all request 4-beat frames with ready=1 -> output order port 0,1,2,3,0; each frame 4 beats; 1 idle cycle between frames.
REQ-038 Port 2 only, with ready toggling 1/0 -> every beat is forwarded exactly once in order; ready[2] follows i_arb_axi_ready; port_id=2 throughout.
REQ-039 Port 1 link drops at beat 3 of 8 -> 3 beats forwarded, then one beat with data MSB=1, keep=0x1, last=1; next grant goes to the next requester after port 1.
REQ-040 Port 3 requesting with link=0 -> never granted; ready[3] stays 0; o_arb_axi_valid stays 0 if no other request.
REQ-041 i_rst asserted during beat 2 of a frame -> next cycle valid=0, busy=0, all ready=0; the next grant goes to port 0 if it is requesting.
REQ-042 Link drop coincident with an accepted last beat -> normal completion, no FLUSH beat emitted.
